// File: rtl/mul_share_pkg.sv
// -----------------------------------------------------------------------------
// mul_share_pkg
//   Shared constants for the time-shared multiplier scheduler: operand and
//   product widths, the requester limit, the scheduler state encoding and the
//   helper that sizes the requester-id fields.
//   No ports (package).
// -----------------------------------------------------------------------------
package mul_share_pkg;

   localparam int XW      = 16;   // X operand width
   localparam int YW      = 9;    // Y operand width
   localparam int PW      = 25;   // full product width, XW+YW
   localparam int MAX_REQ = 8;    // largest supported requester count

   // Scheduler state encoding (kept as plain constants for legacy tools).
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t MUL  = 2'd1;
   localparam state_t DONE = 2'd2;

   // Width of a requester index; never below one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/Multiplier_16_9_d2.sv
// -----------------------------------------------------------------------------
// Multiplier_16_9_d2
//   Combinational 16x9 unsigned multiplier with a full 25-bit product.
//   x : in  16  multiplicand
//   y : in  9   multiplier
//   p : out 25  x*y, exact
// -----------------------------------------------------------------------------
module Multiplier_16_9_d2 (
   input  logic [15:0] x,
   input  logic [8:0]  y,
   output logic [24:0] p
);

   // Both operands widened to the product width so no bit is lost.
   assign p = {9'b0, x} * {16'b0, y};

endmodule

// File: rtl/mul_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mul_rr_arbiter
//   Combinational round-robin arbiter. Searches from ptr upward, wrapping
//   modulo NUM_REQ, and grants the first active request while en is high.
//   req      : in  NUM_REQ  request vector
//   ptr      : in  ID_W     index holding highest priority
//   en       : in  1        grant enable
//   grant    : out NUM_REQ  one-hot grant (all zero when nothing granted)
//   grant_id : out ID_W     index of the granted requester
//   any      : out 1        a grant was issued
// -----------------------------------------------------------------------------
module mul_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the search so no path
      // through the loop leaves a value unassigned (no latches).
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (en && !any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mul_share_sched.sv
// -----------------------------------------------------------------------------
// mul_share_sched
//   Round-robin scheduler time-sharing one Multiplier_16_9_d2 between NUM_REQ
//   requesters. IDLE -> MUL -> DONE; a result is held in DONE until the
//   consumer takes it, and a new grant may be issued in that same cycle.
//   clk       : in  1           rising-edge clock
//   rst       : in  1           synchronous active-high reset
//   req_valid : in  NUM_REQ     per-requester request
//   req_x     : in  NUM_REQ*16  packed X operands, requester i at [16*i+:16]
//   req_y     : in  NUM_REQ*9   packed Y operands, requester i at [9*i+:9]
//   req_ready : out NUM_REQ     one-hot accept; operands sampled this cycle
//   out_valid : out 1           result available
//   out_ready : in  1           consumer accepts result
//   out_prod  : out 25          X*Y, unsigned
//   out_id    : out ID_W        requester owning out_prod
//   busy      : out 1           high whenever not IDLE
// -----------------------------------------------------------------------------
module mul_share_sched
   import mul_share_pkg::*;
#(
   parameter  int NUM_REQ    = 2,
   parameter  int FIRST_PRIO = 0,
   localparam int ID_W       = id_w(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*XW-1:0] req_x,
   input  logic [NUM_REQ*YW-1:0] req_y,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PW-1:0]         out_prod,
   output logic [ID_W-1:0]       out_id,
   output logic                  busy
);

   state_t              state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     next_ptr;
   logic [XW-1:0]       op_x;
   logic [YW-1:0]       op_y;
   logic [ID_W-1:0]     op_id;
   logic [PW-1:0]       mul_p;
   logic                grant_en;
   logic                grant_any;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_id;
   logic [XW-1:0]       sel_x;
   logic [YW-1:0]       sel_y;

   // Grants only when the result slot is free or being emptied this cycle;
   // held off during reset so nothing appears accepted while it is asserted.
   assign grant_en = !rst && ((state == IDLE) || ((state == DONE) && out_ready));

   mul_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .en       (grant_en),
      .grant    (grant),
      .grant_id (grant_id),
      .any      (grant_any)
   );

   assign req_ready = grant;
   assign sel_x     = req_x[grant_id*XW +: XW];
   assign sel_y     = req_y[grant_id*YW +: YW];
   assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   Multiplier_16_9_d2 u_mul (
      .x (op_x),
      .y (op_y),
      .p (mul_p)
   );

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= ID_W'(FIRST_PRIO);
         op_x     <= '0;
         op_y     <= '0;
         op_id    <= '0;
         out_prod <= '0;
         out_id   <= '0;
      end else begin
         case (state)
            IDLE: if (grant_any) state <= MUL;
            MUL: begin
               out_prod <= mul_p;
               out_id   <= op_id;
               state    <= DONE;
            end
            DONE: if (out_ready) state <= grant_any ? MUL : IDLE;
            default: state <= IDLE;
         endcase
         // grant_any can only be high in IDLE or in DONE while draining, so
         // the operand load is safe outside the case.
         if (grant_any) begin
            op_x   <= sel_x;
            op_y   <= sel_y;
            op_id  <= grant_id;
            rr_ptr <= next_ptr;
         end
      end
   end

   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule
